pipeline_hazard_controller: RTL

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller_pkg.sv | 23 ++
 rtl/pipeline_hazard_controller_scoreboard.sv | 47 ++++
 rtl/pipeline_hazard_controller.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared processor package for the hazard controller.
// Holds the hazard FSM encodings, the register-0 constant and the
// scoreboard slot payload.
package pipeline_hazard_controller_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned STATE_W = 2;

  localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);

  typedef enum logic [STATE_W-1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_e;

  // One in-flight writer: does it write the register file, and where.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
  } sb_entry_t;

endpackage

// File: rtl/pipeline_hazard_controller_scoreboard.sv
// hazard_scoreboard: shift register of in-flight writers (EX, MEM, WB, ...).
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   i_issue             - entry entering EX this cycle (bubble = invalid)
//   i_rs, i_rt          - source registers of the instruction in ID
//   o_match_rs/_rt      - some valid slot targets rs / rt (combinational)
module hazard_scoreboard
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  sb_entry_t        i_issue,
  input  logic [REG_W-1:0] i_rs,
  input  logic [REG_W-1:0] i_rt,
  output logic             o_match_rs,
  output logic             o_match_rt
);

  sb_entry_t r_slot [SB_DEPTH];

  // Slot 0 takes the issued entry; older writers shift towards the WB end.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(SB_DEPTH); i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      r_slot[0] <= i_issue;
      for (int i = 1; i < int'(SB_DEPTH); i++) begin
        r_slot[i] <= r_slot[i-1];
      end
    end
  end

  // Any valid pending writer of the register blocks the read.
  always_comb begin
    o_match_rs = 1'b0;
    o_match_rt = 1'b0;
    for (int i = 0; i < int'(SB_DEPTH); i++) begin
      if (r_slot[i].valid && (r_slot[i].dest == i_rs)) o_match_rs = 1'b1;
      if (r_slot[i].valid && (r_slot[i].dest == i_rt)) o_match_rt = 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush control for a non-forwarding
// 5-stage pipeline.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   id_rs/id_rt, id_uses_rs/_rt     - ID source registers and read flags
//   id_dest, id_reg_write           - ID final write register and RegWrite
//   id_jump                         - ID holds j/jal
//   ex_redirect                     - taken branch or jr resolved in EX
//   pc_en, ifid_en                  - PC / IF-ID write enables (combinational)
//   ifid_nop, idex_nop              - pipeline-register nop controls (comb.)
//   stall_count, flush_count        - saturating event counters
//   state_out                       - current FSM state
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned SB_DEPTH  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_W-1:0]     id_rs,
  input  logic [REG_W-1:0]     id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic [REG_W-1:0]     id_dest,
  input  logic                 id_reg_write,
  input  logic                 id_jump,
  input  logic                 ex_redirect,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 ifid_nop,
  output logic                 idex_nop,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count,
  output logic [STATE_W-1:0]   state_out
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  hz_state_e            r_state;
  hz_state_e            w_next_state;
  logic [CNT_WIDTH-1:0] r_stall_count;
  logic [CNT_WIDTH-1:0] r_flush_count;
  logic                 w_match_rs;
  logic                 w_match_rt;
  logic                 w_raw_hazard;
  logic                 w_stall_inc;
  logic                 w_flush_inc;
  sb_entry_t            w_issue;

  hazard_scoreboard #(
    .SB_DEPTH (SB_DEPTH)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .i_issue    (w_issue),
    .i_rs       (id_rs),
    .i_rt       (id_rt),
    .o_match_rs (w_match_rs),
    .o_match_rt (w_match_rt)
  );

  // Register 0 is hardwired, so reads of it never wait on a writer.
  assign w_raw_hazard = (id_uses_rs && (id_rs != REG_ZERO) && w_match_rs) ||
                        (id_uses_rt && (id_rt != REG_ZERO) && w_match_rt);

  // Decision logic: redirect > RAW hazard > jump > normal flow.
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_nop     = 1'b0;
    idex_nop     = 1'b0;
    w_issue      = '0;
    w_next_state = ST_RUN;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;
    if (reset) begin
      ifid_nop = 1'b1;
      idex_nop = 1'b1;
    end else if (ex_redirect) begin
      ifid_nop     = 1'b1;
      idex_nop     = 1'b1;
      w_next_state = ST_FLUSH;
      w_flush_inc  = 1'b1;
    end else if (w_raw_hazard) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_nop     = 1'b1;
      w_next_state = ST_STALL;
      w_stall_inc  = 1'b1;
    end else begin
      w_issue.valid = id_reg_write && (id_dest != REG_ZERO);
      w_issue.dest  = id_dest;
      if (id_jump) begin
        ifid_nop    = 1'b1;
        w_flush_inc = 1'b1;
      end
    end
  end

  // State and saturating counters; a reset cycle never counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_stall_inc && (r_stall_count != CNT_MAX)) begin
        r_stall_count <= r_stall_count + CNT_WIDTH'(1);
      end
      if (w_flush_inc && (r_flush_count != CNT_MAX)) begin
        r_flush_count <= r_flush_count + CNT_WIDTH'(1);
      end
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
  assign state_out   = r_state;

endmodule
